// File: rtl/ace_pkg.sv
// ace_pkg: CRRESP bit positions, channel types and response merge shared by the CCU snoop path
package ace_pkg;
  localparam int CR_DT  = 0;
  localparam int CR_ERR = 1;
  localparam int CR_PD  = 2;
  localparam int CR_IS  = 3;
  localparam int CR_WU  = 4;
  typedef logic [4:0] crresp_t;
  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } cd_t;
  function automatic crresp_t merge_crresp(input crresp_t a, input crresp_t b);
    return a | b;
  endfunction
endpackage

// File: rtl/ace_ccu_sel_fifo.sv
// ace_ccu_sel_fifo: first-word-fall-through FIFO holding snoop fan-out masks
module ace_ccu_sel_fifo #(
  parameter int unsigned Depth = 4,
  parameter type         T     = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);
  localparam int unsigned AW = Depth > 1 ? $clog2(Depth) : 1;
  T mem_q [Depth];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full_o  = cnt_q == (AW+1)'(Depth);
  assign empty_o = cnt_q == '0;
  assign data_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) mem_q[wr_q] <= data_i;
      if (do_push) wr_q <= wr_q == AW'(Depth-1) ? '0 : wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q == AW'(Depth-1) ? '0 : rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/ace_ccu_snoop_resp_merger.sv
// ace_ccu_snoop_resp_merger: collects per-port snoop responses, merges CRRESP, forwards one CD burst
module ace_ccu_snoop_resp_merger import ace_pkg::*; #(
  parameter int unsigned NumOup        = 2,
  parameter int unsigned SelDepth      = 4,
  parameter int unsigned DataBeats     = 4,
  parameter int unsigned TimeoutCycles = 0,
  parameter type         cr_chan_t     = crresp_t,
  parameter type         cd_chan_t     = cd_t
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NumOup-1:0]       sel_i,
  input  logic                    sel_valid_i,
  output logic                    sel_ready_o,
  input  logic [NumOup-1:0]       cr_valids_i,
  output logic [NumOup-1:0]       cr_readies_o,
  input  cr_chan_t [NumOup-1:0]   cr_chans_i,
  input  logic [NumOup-1:0]       cd_valids_i,
  output logic [NumOup-1:0]       cd_readies_o,
  input  cd_chan_t [NumOup-1:0]   cd_chans_i,
  output logic                    cr_valid_o,
  input  logic                    cr_ready_i,
  output cr_chan_t                cr_chan_o,
  output logic                    cd_valid_o,
  input  logic                    cd_ready_i,
  output cd_chan_t                cd_chan_o,
  output logic                    busy_o,
  output logic                    timeout_o
);
  localparam int unsigned OW = NumOup > 1 ? $clog2(NumOup) : 1;
  localparam int unsigned BW = $clog2(DataBeats + 1);
  localparam int unsigned TW = $clog2(TimeoutCycles + 2);
  localparam logic [TW-1:0] TLIM = TW'(TimeoutCycles > 0 ? TimeoutCycles - 1 : 0);
  typedef enum logic [1:0] {IDLE, COLLECT, RESP, DATA} state_e;
  state_e state_q, state_d;
  logic [NumOup-1:0] mask_q, mask_d, got_q, got_d, dt_q, dt_d, done_q, done_d;
  logic [NumOup-1:0] cr_hs, cd_hs, fifo_mask;
  logic [NumOup-1:0][BW-1:0] beat_q;
  cr_chan_t acc_q, acc_d;
  logic [OW-1:0] own;
  logic [TW-1:0] tcnt_q;
  logic timeout_q, pop, empty, full;
  ace_ccu_sel_fifo #(.Depth(SelDepth), .T(logic [NumOup-1:0])) i_sel_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (sel_valid_i),
    .data_i (sel_i),
    .pop_i  (pop),
    .data_o (fifo_mask),
    .full_o (full),
    .empty_o(empty)
  );
  assign sel_ready_o = ~full;
  assign busy_o      = state_q != IDLE || !empty;
  assign timeout_o   = timeout_q;
  assign cr_chan_o   = state_q == RESP ? acc_q : '0;
  assign cd_chan_o   = cd_chans_i[own];
  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    got_d        = got_q;
    dt_d         = dt_q;
    done_d       = done_q;
    acc_d        = acc_q;
    pop          = 1'b0;
    cr_readies_o = '0;
    cd_readies_o = '0;
    cr_valid_o   = 1'b0;
    cd_valid_o   = 1'b0;
    cr_hs        = '0;
    cd_hs        = '0;
    own          = '0;
    for (int j = int'(NumOup) - 1; j >= 0; j--) if (dt_q[j]) own = OW'(j);
    case (state_q)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        mask_d  = fifo_mask;
        got_d   = '0;
        dt_d    = '0;
        acc_d   = '0;
        state_d = |fifo_mask ? COLLECT : RESP;
      end
      COLLECT: begin
        cr_readies_o = mask_q & ~got_q;
        cr_hs        = cr_valids_i & cr_readies_o;
        for (int j = 0; j < int'(NumOup); j++) if (cr_hs[j]) begin
          acc_d = cr_chan_t'(merge_crresp(crresp_t'(acc_d), crresp_t'(cr_chans_i[j])));
          dt_d[j] = cr_chans_i[j][CR_DT];
        end
        got_d = got_q | cr_hs;
        if (got_d == mask_q) state_d = RESP;
      end
      RESP: begin
        cr_valid_o = 1'b1;
        if (cr_ready_i) begin
          state_d = acc_q[CR_DT] ? DATA : IDLE;
          done_d  = ~dt_q;
        end
      end
      default: begin
        for (int j = 0; j < int'(NumOup); j++)
          cd_readies_o[j] = dt_q[j] & ~done_q[j] & (OW'(j) == own ? cd_ready_i : 1'b1);
        cd_valid_o = cd_valids_i[own] & ~done_q[own];
        cd_hs      = cd_valids_i & cd_readies_o;
        for (int j = 0; j < int'(NumOup); j++) if (cd_hs[j] && cd_chans_i[j].last) done_d[j] = 1'b1;
        if (&done_d) state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      got_q     <= '0;
      dt_q      <= '0;
      done_q    <= '0;
      acc_q     <= '0;
      beat_q    <= '0;
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      got_q     <= got_d;
      dt_q      <= dt_d;
      done_q    <= done_d;
      acc_q     <= acc_d;
      for (int j = 0; j < int'(NumOup); j++)
        if (cd_hs[j]) beat_q[j] <= cd_chans_i[j].last ? '0 : beat_q[j] + 1'b1;
      tcnt_q    <= state_q != COLLECT ? '0 : tcnt_q == TLIM ? tcnt_q : tcnt_q + 1'b1;
      timeout_q <= timeout_q | (TimeoutCycles != 0 && state_q == COLLECT && tcnt_q == TLIM);
    end
  end
  for (genvar j = 0; j < NumOup; j++) begin : g_beat_chk
    assert property (@(posedge clk_i) disable iff (rst_i)
      cd_hs[j] |-> (cd_chans_i[j].last == (beat_q[j] == BW'(DataBeats - 1))));
  end
endmodule
